fir_output_requantizer: RTL and testbench

//  Downstream stage of the fixed-point FIR filter. Takes the wide filter sum (WII.WFI), rounds it

---
 rtl/fir_fxp_pkg.sv | 51 +++++
 rtl/fir_output_requantizer_if.sv | 34 +++
 rtl/fir_out_fifo.sv | 69 ++++++
 rtl/fir_output_requantizer.sv | 128 ++++++++++++
 tb/tb_fir_output_requantizer.sv | 308 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fir_fxp_pkg.sv
// fir_fxp_pkg
// Purpose : shared fixed-point definitions for the FIR filter chain.
//           - default WI/WF widths of sample, coefficient and accumulator sum
//           - overflow-code constants carried alongside every sample
//           - round_half_up / saturate helpers operating on a 64-bit signed
//             carrier; callers size-cast the result to their own width.
// Ports   : none (package)
package fir_fxp_pkg;

    // Sample format (filter input and requantizer output)
    localparam int WI1 = 4;
    localparam int WF1 = 5;
    // Coefficient format
    localparam int WIC = 2;
    localparam int WFC = 5;
    // Growth of the accumulator integer part with the number of taps
    localparam int FILT_ORDER = 6;
    // Accumulator sum format
    localparam int WIS = WI1 + WIC + FILT_ORDER;
    localparam int WFS = WF1 + WFC;

    // Overflow code travelling with each sample
    localparam logic [1:0] OVF_NONE = 2'b00;
    localparam logic [1:0] OVF_ONE  = 2'b10;
    localparam logic [1:0] OVF_BOTH = 2'b11;

    typedef logic signed [63:0] fxp_wide_t;

    // Drop 'shift' fraction bits, rounding ties toward +inf.
    // Adding half an LSB then shifting arithmetically gives floor(x/2^s + 1/2).
    function automatic fxp_wide_t round_half_up(input fxp_wide_t x, input int shift);
        fxp_wide_t half;
        half = 64'sd1 <<< (shift - 1);
        return (x + half) >>> shift;
    endfunction

    // Clamp x into the signed range of a 'width'-bit two's complement value.
    function automatic fxp_wide_t saturate(input fxp_wide_t x, input int width);
        fxp_wide_t max_v;
        fxp_wide_t min_v;
        max_v = (64'sd1 <<< (width - 1)) - 64'sd1;
        min_v = -(64'sd1 <<< (width - 1));
        if (x > max_v) begin
            return max_v;
        end else if (x < min_v) begin
            return min_v;
        end
        return x;
    endfunction

endpackage

// File: rtl/fir_output_requantizer_if.sv
// fir_output_requantizer_if
// Purpose : bundles the input (filter sum) and output (requantized sample)
//           valid/ready streams of the requantizer.
// Params  : DIW data width of the incoming sum, DOW width of the output sample
// Signals : in_valid/in_ready/in_data/in_ovf   - upstream stream
//           out_valid/out_ready/out_data/out_ovf/out_sat - downstream stream
// Modports: slave  - the requantizer (consumes in_*, produces out_*)
//           master - the environment around it
interface fir_output_requantizer_if
    import fir_fxp_pkg::*;
#(
    parameter int DIW = WIS + WFS,
    parameter int DOW = WI1 + WF1
);
    logic           in_valid;
    logic           in_ready;
    logic [DIW-1:0] in_data;
    logic [1:0]     in_ovf;
    logic           out_valid;
    logic           out_ready;
    logic [DOW-1:0] out_data;
    logic [1:0]     out_ovf;
    logic           out_sat;

    modport slave (
        input  in_valid, in_data, in_ovf, out_ready,
        output in_ready, out_valid, out_data, out_ovf, out_sat
    );

    modport master (
        output in_valid, in_data, in_ovf, out_ready,
        input  in_ready, out_valid, out_data, out_ovf, out_sat
    );
endinterface

// File: rtl/fir_out_fifo.sv
// fir_out_fifo
// Purpose : small synchronous FIFO with a combinational head. The head reads
//           as zero while empty so downstream sees clean data after reset.
// Params  : WIDTH entry width, DEPTH entries (power of 2, >= 2)
// Ports   : clk, srst      clock, synchronous active-high reset
//           push/push_data write an entry (ignored when full unless popping)
//           pop            remove the head (ignored when empty)
//           head           current oldest entry
//           count          number of stored entries, 0..DEPTH
module fir_out_fifo #(
    parameter int WIDTH = 12,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     srst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW + 1)'(DEPTH);

    // Depth is tiny, so the array maps to LUT RAM with an asynchronous read
    // which lets the head be presented the cycle after it is written.
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [AW:0]      count_reg;
    logic             do_push;
    logic             do_pop;

    // A push into a full FIFO is allowed only alongside a pop: the slot being
    // freed is the one written, and the count stays at DEPTH.
    assign do_pop  = pop && (count_reg != '0);
    assign do_push = push && ((count_reg != FULL) || do_pop);

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_reg] <= push_data;
        end
    end

    // Power-of-2 depth: pointers wrap by natural overflow.
    always_ff @(posedge clk) begin
        if (srst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    assign head  = (count_reg != '0) ? mem[rd_ptr_reg] : '0;
    assign count = count_reg;

endmodule

// File: rtl/fir_output_requantizer.sv
// fir_output_requantizer
// Purpose : rounds (half-up) and saturates the wide FIR sum WII.WFI down to
//           the sample format WIQ.WFQ, then buffers the result in a FIFO
//           behind a valid/ready handshake. The filter overflow code and a
//           local saturation flag travel with each sample.
// Params  : WII, WFI   integer/fraction bits of the input sum
//           WIQ, WFQ   integer/fraction bits of the output sample
//           FIFO_DEPTH output buffer entries (power of 2, >= 2)
// Ports   : CLK        clock, all logic on posedge
//           RESET      synchronous active-high reset, discards everything in flight
//           io         slave side of fir_output_requantizer_if (in_* / out_* streams)
//           sat_count  16-bit saturating count of clipped samples pushed into
//                      the FIFO; present only when REQUANT_SAT_CNT_EN is defined
// Build   : define REQUANT_SAT_CNT_EN to add the sat_count port and counter.
module fir_output_requantizer
    import fir_fxp_pkg::*;
#(
    parameter int WII        = WIS,
    parameter int WFI        = WFS,
    parameter int WIQ        = WI1,
    parameter int WFQ        = WF1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                      CLK,
    input  logic                      RESET,
    fir_output_requantizer_if.slave   io
`ifdef REQUANT_SAT_CNT_EN
    ,
    output logic [15:0]               sat_count
`endif
);
    localparam int WI    = WII + WFI;
    localparam int WO    = WIQ + WFQ;
    localparam int SHIFT = WFI - WFQ;
    // One extra bit absorbs the rounding carry before the shift.
    localparam int W1    = WI + 1 - SHIFT;
    localparam int FW    = WO + 3;
    localparam int CW    = $clog2(FIFO_DEPTH) + 1;

    logic          accept;
    logic          v1_reg;
    logic [W1-1:0] s1_data_reg;
    logic [1:0]    s1_ovf_reg;
    logic          v2_reg;
    logic [WO-1:0] s2_data_reg;
    logic [1:0]    s2_ovf_reg;
    logic          s2_sat_reg;
    fxp_wide_t     s1_wide;
    fxp_wide_t     s2_wide;
    logic [FW-1:0] fifo_head;
    logic [CW-1:0] fifo_count;
    logic [CW:0]   credit_used;

    assign accept = io.in_valid && io.in_ready;

    // Stage 1: round half-up, dropping SHIFT fraction bits.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            v1_reg      <= 1'b0;
            s1_data_reg <= '0;
            s1_ovf_reg  <= OVF_NONE;
        end else begin
            v1_reg <= accept;
            if (accept) begin
                s1_data_reg <= W1'(round_half_up(fxp_wide_t'(signed'(io.in_data)), SHIFT));
                s1_ovf_reg  <= io.in_ovf;
            end
        end
    end

    // Stage 2: clamp to the output range; any change means the sample clipped.
    always_comb begin
        s1_wide = fxp_wide_t'(signed'(s1_data_reg));
        s2_wide = saturate(s1_wide, WO);
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            v2_reg      <= 1'b0;
            s2_data_reg <= '0;
            s2_ovf_reg  <= OVF_NONE;
            s2_sat_reg  <= 1'b0;
        end else begin
            v2_reg <= v1_reg;
            if (v1_reg) begin
                s2_data_reg <= s2_wide[WO-1:0];
                s2_ovf_reg  <= s1_ovf_reg;
                s2_sat_reg  <= (s2_wide != s1_wide);
            end
        end
    end

    fir_out_fifo #(
        .WIDTH (FW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (CLK),
        .srst      (RESET),
        .push      (v2_reg),
        .push_data ({s2_data_reg, s2_ovf_reg, s2_sat_reg}),
        .pop       (io.out_valid && io.out_ready),
        .head      (fifo_head),
        .count     (fifo_count)
    );

    // Credit check: every sample already in the pipeline owns a FIFO slot, so
    // the pipeline never has to stall and nothing is ever dropped.
    assign credit_used = (CW + 1)'(fifo_count) + (CW + 1)'(v1_reg) + (CW + 1)'(v2_reg);
    assign io.in_ready = credit_used < (CW + 1)'(FIFO_DEPTH);

    assign io.out_valid = (fifo_count != '0);
    assign {io.out_data, io.out_ovf, io.out_sat} = fifo_head;

`ifdef REQUANT_SAT_CNT_EN
    logic [15:0] sat_count_reg;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            sat_count_reg <= '0;
        end else if (v2_reg && s2_sat_reg && (sat_count_reg != 16'hFFFF)) begin
            sat_count_reg <= sat_count_reg + 16'd1;
        end
    end

    assign sat_count = sat_count_reg;
`endif

endmodule

// File: tb/tb_fir_output_requantizer.sv
// tb_fir_output_requantizer
// Purpose : scoreboard bench for fir_output_requantizer. Accepted samples are
//           turned into expected outputs by an arithmetic reference model and
//           queued; a monitor pops and compares on every output transfer.
// Build   : define REQUANT_SAT_CNT_EN to also check sat_count.
module tb_fir_output_requantizer;
    import fir_fxp_pkg::*;

    localparam int DIW   = WIS + WFS;
    localparam int DOW   = WI1 + WF1;
    localparam int SHIFT = WFS - WF1;
    localparam int OMAX  = (1 << (DOW - 1)) - 1;
    localparam int OMIN  = -(1 << (DOW - 1));

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    fir_output_requantizer_if #(.DIW(DIW), .DOW(DOW)) io ();

`ifdef REQUANT_SAT_CNT_EN
    logic [15:0] sat_count;
`endif

    fir_output_requantizer dut (
        .CLK   (clk),
        .RESET (rst),
        .io    (io)
`ifdef REQUANT_SAT_CNT_EN
        ,
        .sat_count (sat_count)
`endif
    );

    typedef struct {
        int         data;
        logic [1:0] ovf;
        logic       sat;
        int         t_drive;
        bit         lat_chk;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   errors = 0;
    int   checks = 0;
    int   exp_sat_cnt = 0;
    int   ready_mode = 0;   // 0: always ready, 1: never ready, 2: random

    // Reference: value = x / 2^SHIFT, rounded to nearest with ties up, then clipped.
    function automatic int ref_requant(input int x, output logic sat);
        int num;
        int q;
        num = x + (1 << (SHIFT - 1));
        q   = num / (1 << SHIFT);
        if ((num < 0) && ((num % (1 << SHIFT)) != 0)) q = q - 1;
        sat = 1'b0;
        if (q > OMAX) begin
            q = OMAX; sat = 1'b1;
        end else if (q < OMIN) begin
            q = OMIN; sat = 1'b1;
        end
        return q;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_exp(input int x, input logic [1:0] ovf, input bit lat);
        exp_t e;
        logic s;
        e.data    = ref_requant(x, s);
        e.sat     = s;
        e.ovf     = ovf;
        e.t_drive = cyc;
        e.lat_chk = lat;
        exp_q.push_back(e);
        if (s) exp_sat_cnt++;
        $display("in : x=%0d ovf=%b -> expect data=%0d sat=%0d", x, ovf, e.data, s);
    endtask

    // Present one sample; it is accepted on the posedge after in_ready is seen.
    task automatic send(input int x, input logic [1:0] ovf, input bit lat);
        int n;
        n = 0;
        @(negedge clk);
        io.in_valid = 1'b1;
        io.in_data  = DIW'(x);
        io.in_ovf   = ovf;
        while (!io.in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("accept_timeout", int'(io.in_ready), 1);
        if (io.in_ready) push_exp(x, ovf, lat);
    endtask

    // Idle cycle with junk on the data lines, which must be ignored.
    task automatic idle();
        @(negedge clk);
        io.in_valid = 1'b0;
        io.in_data  = DIW'($urandom);
        io.in_ovf   = 2'($urandom);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk("drain_left", exp_q.size(), 0);
    endtask

    function automatic int rand_x();
        int sel;
        sel = int'($urandom_range(0, 2));
        if (sel == 0) return int'($urandom_range(0, (1 << DIW) - 1)) - (1 << (DIW - 1));
        if (sel == 1) return int'($urandom_range(0, 20000)) - 10000;
        return (($urandom_range(0, 1) == 0) ? 8160 : -8200) + int'($urandom_range(0, 64)) - 32;
    endfunction

    function automatic logic [1:0] rand_ovf();
        int r;
        r = int'($urandom_range(0, 2));
        return (r == 0) ? OVF_NONE : ((r == 1) ? OVF_ONE : OVF_BOTH);
    endfunction

    // out_ready is driven just after the posedge so the monitor sees it stable.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0:       io.out_ready = 1'b1;
                1:       io.out_ready = 1'b0;
                default: io.out_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Monitor / scoreboard
    always @(negedge clk) begin
        if (!rst && io.out_valid && io.out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_output: got data=%0d with nothing expected", $signed(io.out_data));
            end else begin
                mon_e = exp_q.pop_front();
                checks++;
                if (($signed(io.out_data) != mon_e.data) || (io.out_ovf != mon_e.ovf) || (io.out_sat != mon_e.sat)) begin
                    errors++;
                    $display("FAIL sample: got data=%0d ovf=%b sat=%0d expected data=%0d ovf=%b sat=%0d",
                             $signed(io.out_data), io.out_ovf, io.out_sat, mon_e.data, mon_e.ovf, mon_e.sat);
                end else begin
                    $display("out: data=%0d ovf=%b sat=%0d ok", $signed(io.out_data), io.out_ovf, io.out_sat);
                end
                if (mon_e.lat_chk) begin
                    checks++;
                    if (cyc - mon_e.t_drive != 3) begin
                        errors++;
                        $display("FAIL latency: got %0d cycles expected 3", cyc - mon_e.t_drive);
                    end
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc;
        int x;
        io.in_valid  = 1'b0;
        io.in_data   = '0;
        io.in_ovf    = 2'b00;
        io.out_ready = 1'b1;
        rst          = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_out_valid", int'(io.out_valid), 0);
        chk("rst_in_ready", int'(io.in_ready), 1);
        chk("rst_out_data", int'(io.out_data), 0);
        chk("rst_out_ovf", int'(io.out_ovf), 0);
        chk("rst_out_sat", int'(io.out_sat), 0);
`ifdef REQUANT_SAT_CNT_EN
        chk("rst_sat_count", int'(sat_count), 0);
`endif
        rst = 1'b0;

        // 1.5 with an empty FIFO: value and 3-cycle latency
        send(1536, OVF_NONE, 1'b1);
        idle();
        drain();

        // Rounding ties and near-ties
        send(33, OVF_NONE, 1'b0);
        send(15, OVF_NONE, 1'b0);
        send(16, OVF_NONE, 1'b0);
        send(-16, OVF_NONE, 1'b0);
        send(-17, OVF_NONE, 1'b0);
        idle();
        drain();

        // Saturation and the edges of the output range
        send(10240, OVF_NONE, 1'b0);
        send(-9216, OVF_NONE, 1'b0);
        send((1 << (DIW - 1)) - 1, OVF_NONE, 1'b0);
        send(-(1 << (DIW - 1)), OVF_NONE, 1'b0);
        send(8175, OVF_NONE, 1'b0);
        send(8176, OVF_NONE, 1'b0);
        send(-8208, OVF_NONE, 1'b0);
        send(-8209, OVF_NONE, 1'b0);
        idle();
        drain();

        // Overflow code follows only its own sample
        send(100, OVF_NONE, 1'b0);
        send(200, OVF_NONE, 1'b0);
        send(300, OVF_BOTH, 1'b0);
        send(400, OVF_NONE, 1'b0);
        send(500, OVF_ONE, 1'b0);
        idle();
        drain();

        // Back-pressure: exactly FIFO_DEPTH samples get in, then in_ready drops
        ready_mode = 1;
        repeat (2) @(negedge clk);
        acc = 0;
        repeat (12) begin
            @(negedge clk);
            x = rand_x();
            io.in_valid = 1'b1;
            io.in_data  = DIW'(x);
            io.in_ovf   = OVF_NONE;
            if (io.in_ready) begin
                push_exp(x, OVF_NONE, 1'b0);
                acc++;
            end
        end
        chk("fill_accepts", acc, 4);
        chk("full_in_ready", int'(io.in_ready), 0);
        idle();
        ready_mode = 0;
        drain();

        // Randomized traffic with random back-pressure
        ready_mode = 2;
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 3) == 0) idle();
            else send(rand_x(), rand_ovf(), 1'b0);
        end
        idle();
        ready_mode = 0;
        drain();
`ifdef REQUANT_SAT_CNT_EN
        chk("sat_count", int'(sat_count), exp_sat_cnt);
`endif

        // Reset with samples buffered and in flight
        ready_mode = 1;
        repeat (2) @(negedge clk);
        send(10240, OVF_BOTH, 1'b0);
        send(-9216, OVF_NONE, 1'b0);
        send(10240, OVF_ONE, 1'b0);
        send(-9216, OVF_NONE, 1'b0);
        @(negedge clk);
        io.in_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_out_valid", int'(io.out_valid), 0);
        chk("midrst_in_ready", int'(io.in_ready), 1);
`ifdef REQUANT_SAT_CNT_EN
        chk("midrst_sat_count", int'(sat_count), 0);
`endif
        rst = 1'b0;
        exp_q.delete();
        exp_sat_cnt = 0;
        ready_mode = 0;
        repeat (8) begin
            @(negedge clk);
            chk("post_rst_no_stale", int'(io.out_valid), 0);
        end
        send(-17, OVF_ONE, 1'b1);
        idle();
        drain();
`ifdef REQUANT_SAT_CNT_EN
        chk("post_rst_sat_count", int'(sat_count), exp_sat_cnt);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
